clk_gain_meter: RTL and testbench

Receive-side checker for the derived gain clock. It runs in the clk_main domain and measures every clk_gain half-period in clk_main cycles. It flags period errors against the expected ratio, detects timestamp refractory gaps (clk_gain held low), and checks that clk_gain restarts phase-aligned to a clk_low rising edge. It sits downstream of the gain-clock generator and feeds status/debug registers.

---
 rtl/clk_gain_meter.sv | 137 +++++++++++++
 tb/tb_clk_gain_meter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_gain_meter.sv
// Measures clk_gain half-periods in clk_main cycles, tracks lock, refractory gaps
// and gap-exit phase alignment against clk_low.
module clk_gain_meter #(
    parameter int unsigned R_MAIN_TO_LOW = 1000,
    parameter int unsigned G             = 1,
    parameter int unsigned TOL           = 2,
    parameter int unsigned LOCK_N        = 4,
    parameter int unsigned HALF_EXP      = (R_MAIN_TO_LOW + G) / (2 * G),
    parameter int unsigned CNT_W         = $clog2(4 * HALF_EXP),
    parameter int unsigned GAP_W         = 16
) (
    input  logic             clk_main,
    input  logic             clr,
    input  logic             clk_gain,
    input  logic             clk_low,
    input  logic             exp_w1_de1,
    input  logic             err_clr,
    output logic [CNT_W-1:0] half_per,
    output logic             half_valid,
    output logic             locked,
    output logic             gap_active,
    output logic [GAP_W-1:0] gap_cnt,
    output logic             err_period,
    output logic             err_phase
);

    localparam int unsigned CW1    = CNT_W + 1;
    localparam int unsigned GOOD_W = $clog2(LOCK_N + 1);
    localparam int unsigned LO_I   = (HALF_EXP > TOL) ? HALF_EXP - TOL : 0;
    localparam logic [CNT_W:0] LO_LIM = CW1'(LO_I);
    localparam logic [CNT_W:0] HI_LIM = CW1'(HALF_EXP + TOL);
    localparam logic [GOOD_W-1:0] LOCK_V = GOOD_W'(LOCK_N);

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [GOOD_W-1:0] good;
    logic              g_d;
    logic              l_d;
    logic              lr_d;

    logic              edge_s;
    logic              rise_s;
    logic [CNT_W:0]    meas;
    logic              in_tol;
    logic              timeout;
    logic [CNT_W-1:0]  cnt_inc;
    logic [GOOD_W-1:0] good_inc;

    // Measurement is one wider than cnt so a saturated count compares as too long.
    always_comb begin
        edge_s   = clk_gain ^ g_d;
        rise_s   = clk_gain & ~g_d;
        meas     = {1'b0, cnt} + 1'b1;
        in_tol   = (meas >= LO_LIM) && (meas <= HI_LIM);
        timeout  = meas > HI_LIM;
        cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
        good_inc = (good == LOCK_V) ? good : good + 1'b1;
    end

    always_ff @(posedge clk_main) begin
        if (clr) begin
            state      <= IDLE;
            cnt        <= '0;
            good       <= '0;
            g_d        <= 1'b0;
            l_d        <= 1'b0;
            lr_d       <= 1'b0;
            half_per   <= '0;
            half_valid <= 1'b0;
            locked     <= 1'b0;
            gap_active <= 1'b0;
            gap_cnt    <= '0;
            err_period <= 1'b0;
            err_phase  <= 1'b0;
        end else begin
            g_d        <= clk_gain;
            l_d        <= clk_low;
            lr_d       <= clk_low & ~l_d;
            half_valid <= 1'b0;
            // Clears are overridden by any error raised later in this block.
            if (err_clr) begin
                err_period <= 1'b0;
                err_phase  <= 1'b0;
            end
            if (exp_w1_de1) begin
                state      <= IDLE;
                cnt        <= '0;
                good       <= '0;
                locked     <= 1'b0;
                gap_active <= 1'b0;
            end else begin
                cnt <= edge_s ? '0 : cnt_inc;
                case (state)
                    IDLE: begin
                        if (edge_s) state <= RUN;
                    end
                    RUN: begin
                        if (edge_s) begin
                            half_per   <= meas[CNT_W-1:0];
                            half_valid <= 1'b1;
                            if (in_tol) begin
                                good   <= good_inc;
                                locked <= (good_inc == LOCK_V);
                            end else begin
                                err_period <= 1'b1;
                                good       <= '0;
                                locked     <= 1'b0;
                            end
                        end else if (timeout) begin
                            if (!clk_gain) begin
                                state      <= GAP;
                                gap_active <= 1'b1;
                                if (gap_cnt != '1) gap_cnt <= gap_cnt + 1'b1;
                            end else begin
                                err_period <= 1'b1;
                                good       <= '0;
                                locked     <= 1'b0;
                                state      <= IDLE;
                            end
                        end
                    end
                    GAP: begin
                        if (rise_s) begin
                            state      <= RUN;
                            gap_active <= 1'b0;
                            if (!lr_d) err_phase <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_gain_meter.sv
// Randomised and directed bench for clk_gain_meter, checked every cycle against
// a timestamp-based model of the measurement rules.
module tb_clk_gain_meter;

    localparam int HALF  = 500;   // round(1000 / 1 / 2)
    localparam int TOLV  = 2;
    localparam int LOCKN = 4;
    localparam int CW    = 11;    // clog2(4 * 500)
    localparam int GW    = 16;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int GMAX  = (1 << GW) - 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_GAP = 2;

    logic          clk_main   = 1'b0;
    logic          clr        = 1'b1;
    logic          clk_gain   = 1'b0;
    logic          clk_low    = 1'b0;
    logic          exp_w1_de1 = 1'b0;
    logic          err_clr    = 1'b0;
    logic [CW-1:0] half_per;
    logic          half_valid;
    logic          locked;
    logic          gap_active;
    logic [GW-1:0] gap_cnt;
    logic          err_period;
    logic          err_phase;

    int n_checks = 0;
    int n_errors = 0;
    int low_ph   = 600;
    int cyc      = 0;

    clk_gain_meter dut (
        .clk_main  (clk_main),
        .clr       (clr),
        .clk_gain  (clk_gain),
        .clk_low   (clk_low),
        .exp_w1_de1(exp_w1_de1),
        .err_clr   (err_clr),
        .half_per  (half_per),
        .half_valid(half_valid),
        .locked    (locked),
        .gap_active(gap_active),
        .gap_cnt   (gap_cnt),
        .err_period(err_period),
        .err_phase (err_phase)
    );

    always #5 clk_main = ~clk_main;

    // Model state: time since last gain edge, run length of good halves, event flags.
    bit m_ready = 0;
    int m_mode, m_since, m_good, m_half_per, m_gap_cnt;
    bit m_gprev, m_lprev, m_lrise, m_hv, m_gap_act, m_errp, m_errph;

    task model_step();
        int  meas;
        int  dev;
        bit  edge_s;
        bit  rise_s;
        if (clr) begin
            m_ready = 1; m_mode = M_IDLE; m_since = 0; m_good = 0;
            m_gprev = 0; m_lprev = 0; m_lrise = 0; m_half_per = 0; m_hv = 0;
            m_gap_act = 0; m_gap_cnt = 0; m_errp = 0; m_errph = 0;
            return;
        end
        if (!m_ready) return;
        edge_s = (clk_gain != m_gprev);
        rise_s = clk_gain && !m_gprev;
        meas   = m_since + 1;
        dev    = (meas > HALF) ? meas - HALF : HALF - meas;
        m_hv   = 0;
        if (err_clr) begin
            m_errp = 0; m_errph = 0;
        end
        if (exp_w1_de1) begin
            m_mode = M_IDLE; m_since = 0; m_good = 0; m_gap_act = 0;
        end else begin
            if (m_mode == M_IDLE) begin
                if (edge_s) m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                if (edge_s) begin
                    m_half_per = meas % (CMAX + 1);
                    m_hv = 1;
                    if (dev <= TOLV) m_good = (m_good + 1 > LOCKN) ? LOCKN : m_good + 1;
                    else begin m_errp = 1; m_good = 0; end
                end else if (meas > HALF + TOLV) begin
                    if (!clk_gain) begin
                        m_mode = M_GAP; m_gap_act = 1;
                        if (m_gap_cnt < GMAX) m_gap_cnt++;
                    end else begin
                        m_errp = 1; m_good = 0; m_mode = M_IDLE;
                    end
                end
            end else begin
                if (rise_s) begin
                    m_mode = M_RUN; m_gap_act = 0;
                    if (!m_lrise) m_errph = 1;
                end
            end
            m_since = edge_s ? 0 : ((m_since < CMAX) ? m_since + 1 : CMAX);
        end
        m_lrise = clk_low && !m_lprev;
        m_lprev = clk_low;
        m_gprev = clk_gain;
    endtask

    // Inputs change at negedge+1, so at negedge they still hold what the last posedge sampled.
    initial begin
        bit exp_lock;
        forever begin
            @(negedge clk_main);
            cyc++;
            model_step();
            if (m_ready) begin
                exp_lock = (m_good >= LOCKN);
                n_checks++;
                if (half_per !== CW'(m_half_per) || half_valid !== m_hv || locked !== exp_lock ||
                    gap_active !== m_gap_act || gap_cnt !== GW'(m_gap_cnt) ||
                    err_period !== m_errp || err_phase !== m_errph) begin
                    n_errors++;
                    $display("FAIL cycle %0d outputs (dut/model): half_per=%0d/%0d half_valid=%b/%b locked=%b/%b gap_active=%b/%b gap_cnt=%0d/%0d err_period=%b/%b err_phase=%b/%b",
                             cyc, half_per, m_half_per, half_valid, m_hv, locked, exp_lock,
                             gap_active, m_gap_act, gap_cnt, m_gap_cnt, err_period, m_errp,
                             err_phase, m_errph);
                end
            end
        end
    end

    task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_main);
            #1;
            low_ph  = (low_ph + 1) % 1000;
            clk_low = (low_ph < 500);
        end
    endtask

    task half(input int n);
        clk_gain = ~clk_gain;
        step(n);
    endtask

    task pulse_err_clr();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
    endtask

    task gap_fall(input int len);
        if (!clk_gain) half(HALF);
        clk_gain = 1'b0;
        step(len);
    endtask

    // Rise 'off' cycles after clk_low rises; off=1 is the aligned position.
    task gap_rise(input int off);
        step(1);
        while (low_ph != 0) step(1);
        step(off);
        clk_gain = 1'b1;
        step(HALF);
    endtask

    task chk_all_zero(input string tag);
        chk({tag, " half_per"}, 32'(half_per), 0);
        chk({tag, " half_valid"}, 32'(half_valid), 0);
        chk({tag, " locked"}, 32'(locked), 0);
        chk({tag, " gap_active"}, 32'(gap_active), 0);
        chk({tag, " gap_cnt"}, 32'(gap_cnt), 0);
        chk({tag, " err_period"}, 32'(err_period), 0);
        chk({tag, " err_phase"}, 32'(err_phase), 0);
    endtask

    initial begin
        int r;
        clr = 1'b1;
        step(3);
        chk_all_zero("reset");
        clr = 1'b0;
        step(10);

        repeat (5) half(HALF);
        chk("lock half_per", 32'(half_per), 500);
        chk("lock locked", 32'(locked), 1);
        chk("lock err_period", 32'(err_period), 0);

        half(503);
        half(HALF);
        chk("long half_per", 32'(half_per), 503);
        chk("long err_period", 32'(err_period), 1);
        chk("long locked", 32'(locked), 0);
        repeat (4) half(HALF);
        chk("relock locked", 32'(locked), 1);
        chk("relock err_period", 32'(err_period), 1);
        pulse_err_clr();
        chk("err_clr err_period", 32'(err_period), 0);

        gap_fall(3000);
        chk("gap gap_active", 32'(gap_active), 1);
        chk("gap locked", 32'(locked), 1);
        gap_rise(1);
        chk("gap exit gap_active", 32'(gap_active), 0);
        chk("gap exit gap_cnt", 32'(gap_cnt), 1);
        chk("gap exit err_phase", 32'(err_phase), 0);
        chk("gap exit locked", 32'(locked), 1);

        gap_fall(3000);
        gap_rise(5);
        chk("late gap err_phase", 32'(err_phase), 1);
        chk("late gap gap_cnt", 32'(gap_cnt), 2);
        pulse_err_clr();
        chk("err_clr err_phase", 32'(err_phase), 0);

        clk_gain = ~clk_gain;
        exp_w1_de1 = 1'b1;
        step(1);
        exp_w1_de1 = 1'b0;
        chk("abort half_valid", 32'(half_valid), 0);
        step(HALF - 1);
        chk("abort locked", 32'(locked), 0);
        half(501);
        chk("abort no-measure half_per", 32'(half_per), 500);
        half(HALF);
        chk("abort restart half_per", 32'(half_per), 501);

        clk_gain = 1'b1;
        step(600);
        chk("stuck err_period", 32'(err_period), 1);
        chk("stuck locked", 32'(locked), 0);
        clk_gain = 1'b0;
        step(700);
        chk("stuck gap_active", 32'(gap_active), 1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk_all_zero("clr in gap");

        for (int i = 0; i < 50; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55) half(HALF - 3 + int'($urandom_range(0, 6)));
            else if (r < 65) half(int'($urandom_range(400, 600)));
            else if (r < 75) begin
                gap_fall(int'($urandom_range(600, 1500)));
                gap_rise(int'($urandom_range(0, 4)));
            end else if (r < 82) begin
                if ($urandom_range(0, 1) == 1) clk_gain = ~clk_gain;
                exp_w1_de1 = 1'b1;
                step(1);
                exp_w1_de1 = 1'b0;
                step(HALF - 1);
            end else if (r < 90) pulse_err_clr();
            else if (r < 93) begin
                clr = 1'b1;
                step(1);
                clr = 1'b0;
            end else half(int'($urandom_range(1, 3)));
        end

        step(5);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
